// File: rtl/line_window_3x3_pkg.sv
// Shared constants for the 3x3 Bayer window builder: slice indices,
// output latency and the win_data packing helper.
package line_window_3x3_pkg;

  localparam int WIN_LAT = 2;

  // Row-major window slice indices; first digit is row (0 = top), second is column (0 = left)
  localparam int W00 = 0;
  localparam int W01 = 1;
  localparam int W02 = 2;
  localparam int W10 = 3;
  localparam int W11 = 4;
  localparam int W12 = 5;
  localparam int W20 = 6;
  localparam int W21 = 7;
  localparam int W22 = 8;

  function automatic int win_slice_lsb(input int row, input int col, input int dw);
    return (W00 + 3 * row + col) * dw;
  endfunction

endpackage

// File: rtl/line_window_3x3_ram.sv
// Simple dual-port line buffer: read-before-write, one-cycle registered read.
module ram_line #(
  parameter int DATA_WIDTH = 10,
  parameter int ADDR_WIDTH = 11
) (
  input  logic                  clk,
  input  logic                  wren,
  input  logic [ADDR_WIDTH-1:0] wraddr,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  rden,
  input  logic [ADDR_WIDTH-1:0] rdaddr,
  output logic [DATA_WIDTH-1:0] q
);

  logic [DATA_WIDTH-1:0] r_mem [0:(2**ADDR_WIDTH)-1];

  // NOTE: the storage array is deliberately left without reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (rden) q <= r_mem[rdaddr];
    if (wren) r_mem[wraddr] <= data;
  end

endmodule

// File: rtl/line_window_3x3.sv
// Raw Bayer stream to 3x3 neighbourhood: two cascaded line RAMs feed a
// three-column shift bank; window is emitted WIN_LAT cycles after its bottom-right pixel.
module line_window_3x3
  import line_window_3x3_pkg::*;
#(
  parameter int DATA_WIDTH = 10,
  parameter int ADDR_WIDTH = 11
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_vs,
  input  logic                    in_de,
  input  logic [DATA_WIDTH-1:0]   in_data,
  output logic                    win_vld,
  output logic [9*DATA_WIDTH-1:0] win_data,
  output logic [ADDR_WIDTH-1:0]   out_x,
  output logic [ADDR_WIDTH-1:0]   out_y,
  output logic                    out_vs,
  output logic                    err_ovf
);

  localparam int CW = ADDR_WIDTH + 1;
  localparam logic [CW-1:0]         COL_SAT = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH-1:0] ROW_SAT = '1;

  logic [CW-1:0]         r_col;
  logic [ADDR_WIDTH-1:0] r_row;
  logic                  r_de_d1, r_acc_d1, r_cand_d1, r_vs_d1;
  logic [ADDR_WIDTH-1:0] r_col_d1, r_row_d1;
  logic [DATA_WIDTH-1:0] r_data_d1;
  logic [DATA_WIDTH-1:0] r_win [3][3];  // [column][row], column 2 is newest

  logic [DATA_WIDTH-1:0] w_a_q, w_b_q;
  logic                  w_ovf, w_acc, w_fall, w_cand;

  // Overflow pixels and the pixel coinciding with a frame restart never reach the RAMs
  assign w_ovf  = r_col[ADDR_WIDTH];
  assign w_acc  = in_de & ~in_vs & ~w_ovf;
  assign w_fall = r_de_d1 & ~in_de;
  assign w_cand = w_acc & (r_col >= CW'(2)) & (r_row >= ADDR_WIDTH'(2));

  ram_line #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_ram_a (
    .clk    (clk),
    .wren   (w_acc),
    .wraddr (r_col[ADDR_WIDTH-1:0]),
    .data   (in_data),
    .rden   (w_acc),
    .rdaddr (r_col[ADDR_WIDTH-1:0]),
    .q      (w_a_q)
  );

  ram_line #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_ram_b (
    .clk    (clk),
    .wren   (r_acc_d1),
    .wraddr (r_col_d1),
    .data   (w_a_q),
    .rden   (w_acc),
    .rdaddr (r_col[ADDR_WIDTH-1:0]),
    .q      (w_b_q)
  );

  // NOTE: non-blocking assignments so every register samples the pre-edge value of its inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_col   <= '0;
      r_row   <= '0;
      r_de_d1 <= 1'b0;
      err_ovf <= 1'b0;
    end else begin
      r_de_d1 <= in_de;
      if (in_vs) begin
        r_col   <= '0;
        r_row   <= '0;
        err_ovf <= 1'b0;
      end else begin
        if (!in_de)                 r_col <= '0;
        else if (r_col != COL_SAT)  r_col <= r_col + 1'b1;
        if (w_fall && r_row != ROW_SAT) r_row <= r_row + 1'b1;
        if (in_de && w_ovf)         err_ovf <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc_d1  <= 1'b0;
      r_cand_d1 <= 1'b0;
      r_vs_d1   <= 1'b0;
      r_col_d1  <= '0;
      r_row_d1  <= '0;
      r_data_d1 <= '0;
      r_win     <= '{default: '{default: '0}};
      win_vld   <= 1'b0;
      out_x     <= '0;
      out_y     <= '0;
      out_vs    <= 1'b0;
    end else begin
      r_acc_d1  <= w_acc;
      r_cand_d1 <= w_cand;
      r_vs_d1   <= in_vs;
      r_col_d1  <= r_col[ADDR_WIDTH-1:0];
      r_row_d1  <= r_row;
      r_data_d1 <= in_data;
      if (r_acc_d1) begin
        r_win[0]    <= r_win[1];
        r_win[1]    <= r_win[2];
        r_win[2][0] <= w_b_q;
        r_win[2][1] <= w_a_q;
        r_win[2][2] <= r_data_d1;
      end
      // A frame restart drops the window still in flight from the abandoned line
      win_vld <= r_cand_d1 & ~in_vs;
      out_x   <= r_col_d1 - 1'b1;
      out_y   <= r_row_d1 - 1'b1;
      out_vs  <= r_vs_d1;
    end
  end

  for (genvar gr = 0; gr < 3; gr++) begin : g_row
    for (genvar gc = 0; gc < 3; gc++) begin : g_col
      assign win_data[win_slice_lsb(gr, gc, DATA_WIDTH) +: DATA_WIDTH] = r_win[gc][gr];
    end
  end

endmodule
